scoreboarded_register_file: RTL and testbench
=============================================

# scoreboarded_register_file

Parametrised general-purpose register file for the core, the successor to the fixed 16×32, two-read-port file. It generalises width, depth and read-port count and adds an optional hardwired-zero register and write-to-read bypass. It also adds a per-register busy scoreboard, so the decoder can reserve a destination at issue and detect RAW/WAW hazards before the executor writes back. It sits between decode (read addresses, reservations) and execute/writeback (write port).

## Interface
- XLEN, 32, data width in bits
- NREGS, 16, number of architectural registers (≥2; need not be a power of two)
- NREAD, 2, number of independent read ports (≥1)
- ZERO_REG, 1, 1 = register 0 reads as zero, is never written and is never busy
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching read ports
- AW (localparam), $clog2(NREGS), address width
- clock  input  1  single clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- rd_addr  input  NREAD*AW  read addresses; port i = bits [i*AW +: AW]
- rd_data  output  NREAD*XLEN  read data; port i = bits [i*XLEN +: XLEN]
- rd_busy  output  NREAD  1 = register on port i has an outstanding reservation (hazard)
- wr_en  input  1  write strobe
- wr_addr  input  AW  write address
- wr_data  input  XLEN  write data
- rsv_en  input  1  request to reserve a destination register
- rsv_addr  input  AW  register to reserve
- rsv_grant  output  1  combinational; 1 = the reservation is accepted this cycle
- busy_count  output  $clog2(NREGS+1)  number of currently busy registers

## Operation
- State: regs[NREGS] of XLEN bits, busy[NREGS] bits, busy_count register.
- Reset (reset=1 at rising edge): all regs = 0, all busy = 0, busy_count = 0. Outputs after reset: rd_data = 0, rd_busy = 0, rsv_grant follows rsv_en, subject to the rules below with all busy clear.
- Read (combinational), per port i:
  - if the address is ≥ NREGS, data = 0 and busy = 0;
  - else if ZERO_REG and the address is 0, data = 0 and busy = 0;
  - else if BYPASS, wr_en is set and wr_addr equals the address, data = wr_data and busy = 0;
  - otherwise data = regs[addr] and busy = busy[addr].
- Write: at the rising edge with wr_en, regs[wr_addr] ← wr_data and busy[wr_addr] ← 0. The write is ignored if wr_addr ≥ NREGS or (ZERO_REG and wr_addr = 0). Writing a non-busy register is legal (untracked write) and leaves busy at 0.
- Reserve: rsv_grant = rsv_en & ~busy_eff[rsv_addr], where busy_eff = busy[rsv_addr] & ~(wr_en & wr_addr == rsv_addr).
  - On grant, busy[rsv_addr] ← 1 at the edge.
  - A busy register (WAW) is refused: grant 0, no state change. The requester must hold and retry.
  - Out-of-range rsv_addr: grant 0.
  - ZERO_REG with rsv_addr 0: grant 1 and busy stays 0.
- Simultaneous write and granted reserve to the same register: the reserve wins, so busy ends at 1 and regs takes wr_data.
- busy_count is updated by (+1 if a grant set a bit) + (−1 if the write cleared a set bit), so net 0 when both happen. It never wraps: it stays within 0..NREGS-(ZERO_REG?1:0).
- reset asserted mid-operation overrides any same-cycle write or reserve.

## Timing
- Read latency 0 (combinational from rd_addr, and from wr_* when BYPASS=1).
- Write visible on a non-bypassed read in the cycle after the edge; visible the same cycle with BYPASS=1.
- Reservation is visible on rd_busy the cycle after the grant edge.
- rsv_grant is combinational from rsv_en/rsv_addr/wr_*; no combinational path from rd_addr to rsv_grant.
- No multi-cycle handshakes; every accepted operation completes at the next rising edge.

## Test plan
- Reset with default parameters: assert reset for 1 cycle while wr_en=1 to x3 → after reset, all rd_data=0, rd_busy=0, busy_count=0.
- Write x5=0xDEADBEEF, then read x5 on both ports the next cycle → both ports return 0xDEADBEEF. With BYPASS=1, reading x5 in the same cycle as the write also returns 0xDEADBEEF. Writing x0 then reading x0 → returns 0.
- Reserve x7 → rsv_grant=1, next cycle rd_busy=1 and busy_count=1. Reserve x7 again → grant=0, busy_count stays 1. Write x7=0x12 → next cycle busy=0, busy_count=0, data=0x12.
- Same cycle: write x7 (busy) and reserve x7 → grant=1, busy_count unchanged, x7 busy next cycle with the new data.
- NREGS=12, NREAD=3, XLEN=64: read addr 13 → data 0, busy 0; write/reserve addr 14 → ignored, grant 0. Reserve all of x1..x11 → busy_count=11, then reserve x0 → grant=1 and busy_count stays 11.

Source files
------------

// File: rtl/scoreboarded_register_file.sv
// Purpose: parametrised register file with per-register busy scoreboard, hardwired zero and write bypass.
// Latency: reads and rsv_grant are combinational; writes and reservations take effect at the next rising edge.
// Backpressure: a reservation on a busy register is refused (grant 0); the requester holds and retries.
//
// Ports:
//   i_clock, i_reset            single clock, synchronous active-high reset
//   i_rd_addr / o_rd_data       NREAD packed read ports (port i at [i*AW +: AW] / [i*XLEN +: XLEN])
//   o_rd_busy                   per-port hazard flag: addressed register has an outstanding reservation
//   i_wr_en/addr/data           writeback port; a write clears the register's busy bit
//   i_rsv_en/addr, o_rsv_grant  destination reservation request and its combinational grant
//   o_busy_count                number of registers currently busy
module scoreboarded_register_file #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 16,
    parameter int NREAD    = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1,
    localparam int AW      = $clog2(NREGS),
    localparam int CW      = $clog2(NREGS + 1)
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [NREAD*AW-1:0]   i_rd_addr,
    output logic [NREAD*XLEN-1:0] o_rd_data,
    output logic [NREAD-1:0]      o_rd_busy,
    input  logic                  i_wr_en,
    input  logic [AW-1:0]         i_wr_addr,
    input  logic [XLEN-1:0]       i_wr_data,
    input  logic                  i_rsv_en,
    input  logic [AW-1:0]         i_rsv_addr,
    output logic                  o_rsv_grant,
    output logic [CW-1:0]         o_busy_count
);

    localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

    logic [XLEN-1:0] r_regs [NREGS];
    logic [NREGS-1:0] r_busy;
    logic [CW-1:0]    r_busy_count;

    logic w_wr_ok;       // write lands in a real, writable register
    logic w_wr_clears;   // that register was busy, so the count drops
    logic w_rsv_zero;    // reservation of the hardwired zero register
    logic w_rsv_busy;    // busy bit of the reservation target
    logic w_rsv_set;     // granted reservation that actually sets a busy bit

    logic [NREAD*XLEN-1:0] w_rd_data;
    logic [NREAD-1:0]      w_rd_busy;

    // Write qualification and the busy bit it would clear.
    always_comb begin
        w_wr_ok     = i_wr_en && ({1'b0, i_wr_addr} < NREGS_W)
                      && !(ZERO_REG && (i_wr_addr == '0));
        w_wr_clears = 1'b0;
        for (int r = 0; r < NREGS; r++) begin
            if (w_wr_ok && (i_wr_addr == AW'(r)) && r_busy[r]) begin
                w_wr_clears = 1'b1;
            end
        end
    end

    // Reservation grant. A same-cycle write to the target frees it, so the
    // reservation is accepted and re-sets busy (reserve wins over write clear).
    always_comb begin
        w_rsv_zero = ZERO_REG && (i_rsv_addr == '0);
        w_rsv_busy = 1'b0;
        for (int r = 0; r < NREGS; r++) begin
            if (i_rsv_addr == AW'(r)) begin
                w_rsv_busy = r_busy[r];
            end
        end
        o_rsv_grant = i_rsv_en && ({1'b0, i_rsv_addr} < NREGS_W)
                      && (w_rsv_zero
                          || !(w_rsv_busy && !(i_wr_en && (i_wr_addr == i_rsv_addr))));
        w_rsv_set   = o_rsv_grant && !w_rsv_zero;
    end

    // Read ports: out-of-range and zero register read 0/not busy; bypass
    // forwards the in-flight write and hides the busy bit it is about to clear.
    always_comb begin
        w_rd_data = '0;
        w_rd_busy = '0;
        for (int i = 0; i < NREAD; i++) begin
            if (ZERO_REG && (i_rd_addr[i*AW +: AW] == '0)) begin
                w_rd_data[i*XLEN +: XLEN] = '0;
                w_rd_busy[i]              = 1'b0;
            end else if (BYPASS && i_wr_en && (i_wr_addr == i_rd_addr[i*AW +: AW])
                         && ({1'b0, i_wr_addr} < NREGS_W)) begin
                w_rd_data[i*XLEN +: XLEN] = i_wr_data;
                w_rd_busy[i]              = 1'b0;
            end else begin
                for (int r = 0; r < NREGS; r++) begin
                    if (i_rd_addr[i*AW +: AW] == AW'(r)) begin
                        w_rd_data[i*XLEN +: XLEN] = r_regs[r];
                        w_rd_busy[i]              = r_busy[r];
                    end
                end
            end
        end
    end

    assign o_rd_data    = w_rd_data;
    assign o_rd_busy    = w_rd_busy;
    assign o_busy_count = r_busy_count;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int r = 0; r < NREGS; r++) begin
                r_regs[r] <= '0;
            end
            r_busy       <= '0;
            r_busy_count <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (w_wr_ok && (i_wr_addr == AW'(r))) begin
                    r_regs[r] <= i_wr_data;
                    r_busy[r] <= 1'b0;
                end
                // Later assignment: a granted reservation overrides the write clear.
                if (w_rsv_set && (i_rsv_addr == AW'(r))) begin
                    r_busy[r] <= 1'b1;
                end
            end
            r_busy_count <= r_busy_count + CW'(w_rsv_set) - CW'(w_wr_clears);
        end
    end

endmodule

// File: tb/tb_scoreboarded_register_file.sv
module tb_scoreboarded_register_file;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // DUT A: default parameters (XLEN=32, NREGS=16, NREAD=2)
    logic        a_reset;
    logic [7:0]  a_rd_addr;
    logic [63:0] a_rd_data;
    logic [1:0]  a_rd_busy;
    logic        a_wr_en;
    logic [3:0]  a_wr_addr;
    logic [31:0] a_wr_data;
    logic        a_rsv_en;
    logic [3:0]  a_rsv_addr;
    logic        a_rsv_grant;
    logic [4:0]  a_busy_count;

    // DUT B: XLEN=64, NREGS=12, NREAD=3
    logic         b_reset;
    logic [11:0]  b_rd_addr;
    logic [191:0] b_rd_data;
    logic [2:0]   b_rd_busy;
    logic         b_wr_en;
    logic [3:0]   b_wr_addr;
    logic [63:0]  b_wr_data;
    logic         b_rsv_en;
    logic [3:0]   b_rsv_addr;
    logic         b_rsv_grant;
    logic [3:0]   b_busy_count;

    scoreboarded_register_file u_a (
        .i_clock      (clk),
        .i_reset      (a_reset),
        .i_rd_addr    (a_rd_addr),
        .o_rd_data    (a_rd_data),
        .o_rd_busy    (a_rd_busy),
        .i_wr_en      (a_wr_en),
        .i_wr_addr    (a_wr_addr),
        .i_wr_data    (a_wr_data),
        .i_rsv_en     (a_rsv_en),
        .i_rsv_addr   (a_rsv_addr),
        .o_rsv_grant  (a_rsv_grant),
        .o_busy_count (a_busy_count)
    );

    scoreboarded_register_file #(
        .XLEN  (64),
        .NREGS (12),
        .NREAD (3)
    ) u_b (
        .i_clock      (clk),
        .i_reset      (b_reset),
        .i_rd_addr    (b_rd_addr),
        .o_rd_data    (b_rd_data),
        .o_rd_busy    (b_rd_busy),
        .i_wr_en      (b_wr_en),
        .i_wr_addr    (b_wr_addr),
        .i_wr_data    (b_wr_data),
        .i_rsv_en     (b_rsv_en),
        .i_rsv_addr   (b_rsv_addr),
        .o_rsv_grant  (b_rsv_grant),
        .o_busy_count (b_busy_count)
    );

    typedef struct {
        logic        wr_en;
        logic [3:0]  wr_addr;
        logic [31:0] wr_data;
        logic        rsv_en;
        logic [3:0]  rsv_addr;
        logic [3:0]  ra0;
        logic [3:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  ebusy;   // {port1, port0}
        logic        egrant;
        logic [4:0]  ecount;
    } vec_t;

    vec_t vt [17];

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic a_idle();
        a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0;
        a_rsv_en = 1'b0; a_rsv_addr = '0;
    endtask

    task automatic b_idle();
        b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0;
        b_rsv_en = 1'b0; b_rsv_addr = '0;
    endtask

    initial begin
        //        wr  wa     wdata         rsv ra    rd0   rd1   exp0          exp1          busy   g     cnt
        vt[0]  = '{0, 4'd0, 32'h0,         0, 4'd0, 4'd3, 4'd5, 32'h0,        32'h0,        2'b00, 1'b0, 5'd0};
        vt[1]  = '{1, 4'd5, 32'hDEADBEEF,  0, 4'd0, 4'd5, 4'd5, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 1'b0, 5'd0};
        vt[2]  = '{0, 4'd0, 32'h0,         0, 4'd0, 4'd5, 4'd5, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 1'b0, 5'd0};
        vt[3]  = '{1, 4'd0, 32'hFFFFFFFF,  0, 4'd0, 4'd0, 4'd5, 32'h0,        32'hDEADBEEF, 2'b00, 1'b0, 5'd0};
        vt[4]  = '{0, 4'd0, 32'h0,         0, 4'd0, 4'd0, 4'd3, 32'h0,        32'h0,        2'b00, 1'b0, 5'd0};
        vt[5]  = '{0, 4'd0, 32'h0,         1, 4'd7, 4'd7, 4'd5, 32'h0,        32'hDEADBEEF, 2'b00, 1'b1, 5'd0};
        vt[6]  = '{0, 4'd0, 32'h0,         1, 4'd7, 4'd7, 4'd0, 32'h0,        32'h0,        2'b01, 1'b0, 5'd1};
        vt[7]  = '{1, 4'd7, 32'h12,        0, 4'd0, 4'd7, 4'd1, 32'h12,       32'h0,        2'b00, 1'b0, 5'd1};
        vt[8]  = '{0, 4'd0, 32'h0,         0, 4'd0, 4'd7, 4'd7, 32'h12,       32'h12,       2'b00, 1'b0, 5'd0};
        vt[9]  = '{0, 4'd0, 32'h0,         1, 4'd7, 4'd7, 4'd7, 32'h12,       32'h12,       2'b00, 1'b1, 5'd0};
        vt[10] = '{1, 4'd7, 32'h34,        1, 4'd7, 4'd7, 4'd2, 32'h34,       32'h0,        2'b00, 1'b1, 5'd1};
        vt[11] = '{0, 4'd0, 32'h0,         0, 4'd0, 4'd7, 4'd7, 32'h34,       32'h34,       2'b11, 1'b0, 5'd1};
        vt[12] = '{0, 4'd0, 32'h0,         1, 4'd0, 4'd0, 4'd7, 32'h0,        32'h34,       2'b10, 1'b1, 5'd1};
        vt[13] = '{1, 4'd9, 32'h99,        1, 4'd9, 4'd9, 4'd7, 32'h99,       32'h34,       2'b10, 1'b1, 5'd1};
        vt[14] = '{0, 4'd0, 32'h0,         0, 4'd0, 4'd9, 4'd7, 32'h99,       32'h34,       2'b11, 1'b0, 5'd2};
        vt[15] = '{1, 4'd7, 32'h56,        0, 4'd0, 4'd9, 4'd7, 32'h99,       32'h56,       2'b01, 1'b0, 5'd2};
        vt[16] = '{0, 4'd0, 32'h0,         0, 4'd0, 4'd7, 4'd9, 32'h56,       32'h99,       2'b10, 1'b0, 5'd1};

        a_reset = 1'b1; a_idle(); a_rd_addr = '0;
        b_reset = 1'b1; b_idle(); b_rd_addr = '0;

        // Reset while a write to x3 is presented: the write must be discarded.
        @(posedge clk); #1;
        a_wr_en = 1'b1; a_wr_addr = 4'd3; a_wr_data = 32'h55;
        @(posedge clk); #1;
        a_reset = 1'b0; b_reset = 1'b0;
        a_idle(); b_idle();
        a_rd_addr = {4'd2, 4'd1};
        @(negedge clk);
        check("rst rd_data", a_rd_data, 64'h0);
        check("rst rd_busy", {62'h0, a_rd_busy}, 64'h0);
        check("rst busy_count", {59'h0, a_busy_count}, 64'h0);
        @(posedge clk); #1;

        // Table-driven sequence on DUT A; each row is one cycle.
        for (int k = 0; k < 17; k++) begin
            a_wr_en = vt[k].wr_en; a_wr_addr = vt[k].wr_addr; a_wr_data = vt[k].wr_data;
            a_rsv_en = vt[k].rsv_en; a_rsv_addr = vt[k].rsv_addr;
            a_rd_addr = {vt[k].ra1, vt[k].ra0};
            @(negedge clk);
            check($sformatf("v%0d rd0", k), {32'h0, a_rd_data[31:0]}, {32'h0, vt[k].e0});
            check($sformatf("v%0d rd1", k), {32'h0, a_rd_data[63:32]}, {32'h0, vt[k].e1});
            check($sformatf("v%0d busy", k), {62'h0, a_rd_busy}, {62'h0, vt[k].ebusy});
            check($sformatf("v%0d grant", k), {63'h0, a_rsv_grant}, {63'h0, vt[k].egrant});
            check($sformatf("v%0d count", k), {59'h0, a_busy_count}, {59'h0, vt[k].ecount});
            @(posedge clk); #1;
        end

        // Reset mid-operation overrides same-cycle write and reserve.
        a_reset = 1'b1;
        a_wr_en = 1'b1; a_wr_addr = 4'd9; a_wr_data = 32'hAA;
        a_rsv_en = 1'b1; a_rsv_addr = 4'd10;
        @(posedge clk); #1;
        a_reset = 1'b0; a_idle();
        a_rd_addr = {4'd10, 4'd9};
        @(negedge clk);
        check("midrst rd_data", a_rd_data, 64'h0);
        check("midrst rd_busy", {62'h0, a_rd_busy}, 64'h0);
        check("midrst count", {59'h0, a_busy_count}, 64'h0);
        @(posedge clk); #1;

        // DUT B: out-of-range reads, write and reserve.
        b_rd_addr = {4'd15, 4'd14, 4'd13};
        b_wr_en = 1'b1; b_wr_addr = 4'd14; b_wr_data = 64'hCAFEF00D_12345678;
        b_rsv_en = 1'b1; b_rsv_addr = 4'd14;
        @(negedge clk);
        check("B oor rd_data", b_rd_data[63:0] | b_rd_data[127:64] | b_rd_data[191:128], 64'h0);
        check("B oor rd_busy", {61'h0, b_rd_busy}, 64'h0);
        check("B oor grant", {63'h0, b_rsv_grant}, 64'h0);
        @(posedge clk); #1;
        b_idle();
        b_rd_addr = {4'd14, 4'd2, 4'd2};
        @(negedge clk);
        check("B oor no alias", b_rd_data[63:0], 64'h0);
        check("B oor count", {60'h0, b_busy_count}, 64'h0);
        @(posedge clk); #1;

        // Reserve x1..x11: every grant accepted.
        for (int r = 1; r < 12; r++) begin
            b_rsv_en = 1'b1; b_rsv_addr = 4'(r);
            @(negedge clk);
            check($sformatf("B rsv x%0d grant", r), {63'h0, b_rsv_grant}, 64'h1);
            @(posedge clk); #1;
        end

        // Reserve x0 with all others busy: granted, count does not move.
        b_rsv_en = 1'b1; b_rsv_addr = 4'd0;
        b_rd_addr = {4'd0, 4'd1, 4'd11};
        @(negedge clk);
        check("B rsv x0 grant", {63'h0, b_rsv_grant}, 64'h1);
        check("B full count", {60'h0, b_busy_count}, 64'd11);
        check("B full rd_busy", {61'h0, b_rd_busy}, 64'h3);
        @(posedge clk); #1;
        b_idle();
        b_rsv_en = 1'b1; b_rsv_addr = 4'd5;
        @(negedge clk);
        check("B after x0 count", {60'h0, b_busy_count}, 64'd11);
        check("B waw x5 grant", {63'h0, b_rsv_grant}, 64'h0);
        @(posedge clk); #1;

        // Writeback of a busy 64-bit register.
        b_idle();
        b_wr_en = 1'b1; b_wr_addr = 4'd11; b_wr_data = 64'h01234567_89ABCDEF;
        b_rd_addr = {4'd0, 4'd1, 4'd11};
        @(negedge clk);
        check("B bypass64", b_rd_data[63:0], 64'h01234567_89ABCDEF);
        @(posedge clk); #1;
        b_idle();
        @(negedge clk);
        check("B wb count", {60'h0, b_busy_count}, 64'd10);
        check("B wb data", b_rd_data[63:0], 64'h01234567_89ABCDEF);
        check("B wb busy", {61'h0, b_rd_busy}, 64'h2);
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
